// File: rtl/dist_pair_sequencer_if.sv
// Control handshake and data-memory bus of the pair-distance sequencer.
interface dist_pair_sequencer_if;
  logic        start;
  logic        done;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_rd_data;
  logic        mem_wr_en;
  logic [7:0]  mem_wr_data;
  logic [15:0] min_dist;
  logic [15:0] max_dist;
  logic [4:0]  min_k;
  logic [4:0]  min_j;
  logic [4:0]  max_k;
  logic [4:0]  max_j;

  // Sequencer side
  modport slave (
    input  start, mem_rd_data,
    output done, mem_addr, mem_wr_en, mem_wr_data,
    output min_dist, max_dist, min_k, min_j, max_k, max_j
  );

  // Host / memory side
  modport master (
    output start, mem_rd_data,
    input  done, mem_addr, mem_wr_en, mem_wr_data,
    input  min_dist, max_dist, min_k, min_j, max_k, max_j
  );
endinterface

// File: rtl/dist_pair_sequencer.sv
// Loads 32 signed 16-bit operands, scans all pairs j<k for min/max |a[j]-a[k]|,
// then writes Min/Max back to the byte-wide data memory.
module dist_pair_sequencer #(
  parameter int unsigned NVAL     = 32,
  parameter int unsigned SRC_BASE = 0,
  parameter int unsigned RES_BASE = 66
) (
  input  logic                  clk,
  input  logic                  reset,
  dist_pair_sequencer_if.slave  bus
);

  localparam int unsigned IW = 5;
  localparam int unsigned BW = 6;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PAIR, S_WRITE, S_DONE} state_t;

  state_t          r_state, w_state_n;
  logic [BW-1:0]   r_bcnt, w_bcnt_n;
  logic [IW-1:0]   r_j, w_j_n, r_k, w_k_n;
  logic [AW-1:0]   r_addr, w_addr_n;
  logic            r_wr_en, w_wr_en_n;
  logic [7:0]      r_wr_data, w_wr_data_n;
  logic            r_done, w_done_n;
  logic [DW-1:0]   r_min, w_min_n, r_max, w_max_n;
  logic [IW-1:0]   r_min_k, w_min_k_n, r_min_j, w_min_j_n;
  logic [IW-1:0]   r_max_k, w_max_k_n, r_max_j, w_max_j_n;
  logic            w_cap_en;
  logic [DW-1:0]   r_cache [NVAL];
  logic [DW:0]     w_diff;
  logic [DW-1:0]   w_dist;

  // Distance of the current pair from 17-bit sign-extended operands
  always_comb begin
    w_diff = {r_cache[r_j][DW-1], r_cache[r_j]} - {r_cache[r_k][DW-1], r_cache[r_k]};
    w_dist = w_diff[DW] ? DW'((DW+1)'(0) - w_diff) : w_diff[DW-1:0];
  end

  // Next-state, counters and registered outputs
  always_comb begin
    w_state_n   = r_state;
    w_bcnt_n    = r_bcnt;
    w_j_n       = r_j;
    w_k_n       = r_k;
    w_addr_n    = r_addr;
    w_wr_en_n   = r_wr_en;
    w_wr_data_n = r_wr_data;
    w_done_n    = r_done;
    w_min_n     = r_min;
    w_max_n     = r_max;
    w_min_k_n   = r_min_k;
    w_min_j_n   = r_min_j;
    w_max_k_n   = r_max_k;
    w_max_j_n   = r_max_j;
    w_cap_en    = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_state_n = S_LOAD;
          w_bcnt_n  = '0;
          w_addr_n  = AW'(SRC_BASE);
          w_done_n  = 1'b0;
          w_min_n   = '1;
          w_max_n   = '0;
          w_min_k_n = '0;
          w_min_j_n = '0;
          w_max_k_n = '0;
          w_max_j_n = '0;
        end
      end
      S_LOAD: begin
        w_cap_en = 1'b1;
        if (r_bcnt == BW'(2*NVAL-1)) begin
          w_state_n = S_PAIR;
          w_bcnt_n  = '0;
          w_addr_n  = '0;
          w_j_n     = '0;
          w_k_n     = IW'(1);
        end else begin
          w_bcnt_n = r_bcnt + BW'(1);
          w_addr_n = AW'(SRC_BASE) + AW'(r_bcnt) + AW'(1);
        end
      end
      S_PAIR: begin
        // First pair seeds both extremes; later pairs need a strict improvement
        if (r_j == '0 && r_k == IW'(1)) begin
          w_min_n = w_dist; w_min_k_n = r_k; w_min_j_n = r_j;
          w_max_n = w_dist; w_max_k_n = r_k; w_max_j_n = r_j;
        end else begin
          if (w_dist < r_min) begin
            w_min_n = w_dist; w_min_k_n = r_k; w_min_j_n = r_j;
          end
          if (w_dist > r_max) begin
            w_max_n = w_dist; w_max_k_n = r_k; w_max_j_n = r_j;
          end
        end
        if (r_k == IW'(NVAL-1)) begin
          if (r_j == IW'(NVAL-2)) begin
            w_state_n   = S_WRITE;
            w_bcnt_n    = '0;
            w_addr_n    = AW'(RES_BASE);
            w_wr_en_n   = 1'b1;
            w_wr_data_n = w_min_n[15:8];
          end else begin
            w_j_n = r_j + IW'(1);
            w_k_n = r_j + IW'(2);
          end
        end else begin
          w_k_n = r_k + IW'(1);
        end
      end
      S_WRITE: begin
        if (r_bcnt == BW'(3)) begin
          w_state_n   = S_DONE;
          w_bcnt_n    = '0;
          w_addr_n    = '0;
          w_wr_en_n   = 1'b0;
          w_wr_data_n = '0;
          w_done_n    = 1'b1;
        end else begin
          w_bcnt_n = r_bcnt + BW'(1);
          w_addr_n = AW'(RES_BASE) + AW'(r_bcnt) + AW'(1);
          case (r_bcnt[1:0])
            2'd0:    w_wr_data_n = r_min[7:0];
            2'd1:    w_wr_data_n = r_max[15:8];
            default: w_wr_data_n = r_max[7:0];
          endcase
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_bcnt    <= '0;
      r_j       <= '0;
      r_k       <= '0;
      r_addr    <= '0;
      r_wr_en   <= 1'b0;
      r_wr_data <= '0;
      r_done    <= 1'b0;
      r_min     <= '1;
      r_max     <= '0;
      r_min_k   <= '0;
      r_min_j   <= '0;
      r_max_k   <= '0;
      r_max_j   <= '0;
    end else begin
      r_state   <= w_state_n;
      r_bcnt    <= w_bcnt_n;
      r_j       <= w_j_n;
      r_k       <= w_k_n;
      r_addr    <= w_addr_n;
      r_wr_en   <= w_wr_en_n;
      r_wr_data <= w_wr_data_n;
      r_done    <= w_done_n;
      r_min     <= w_min_n;
      r_max     <= w_max_n;
      r_min_k   <= w_min_k_n;
      r_min_j   <= w_min_j_n;
      r_max_k   <= w_max_k_n;
      r_max_j   <= w_max_j_n;
    end
  end

  // Operand cache, big-endian byte capture; deliberately not reset
  always_ff @(posedge clk) begin
    if (w_cap_en) begin
      if (!r_bcnt[0]) r_cache[r_bcnt[BW-1:1]][15:8] <= bus.mem_rd_data;
      else            r_cache[r_bcnt[BW-1:1]][7:0]  <= bus.mem_rd_data;
    end
  end

  assign bus.done        = r_done;
  assign bus.mem_addr    = r_addr;
  assign bus.mem_wr_en   = r_wr_en;
  assign bus.mem_wr_data = r_wr_data;
  assign bus.min_dist    = r_min;
  assign bus.max_dist    = r_max;
  assign bus.min_k       = r_min_k;
  assign bus.min_j       = r_min_j;
  assign bus.max_k       = r_max_k;
  assign bus.max_j       = r_max_j;

endmodule

// File: doc/dist_pair_sequencer.md
Name: dist_pair_sequencer

Overview:
- Hardware sequencer for the program-2 workload: finds the min and max arithmetic distance over all pairs of 32 signed 16-bit values held in the byte-wide data memory.
- Owns the data-memory port while busy. Loads the 32 operands, walks the triangular pair space (j<k) one pair per cycle, then writes Min/Max back to memory. Raises done for the top-level handshake.
- Serves as the golden hardware accelerator against which top_level results are cross-checked.

Parameters:
- NVAL, 32: number of 16-bit operands (fixed 32 in this release; index width 5).
- SRC_BASE, 0: byte address of operand 0.
- RES_BASE, 66: byte address of result block. Min is at RES_BASE/+1; Max is at RES_BASE+2/+3.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE and DONE.
- done  out  1  acknowledge; high only in DONE.
- mem_addr  out  8  data-memory byte address.
- mem_rd_data  in  8  data-memory read data (combinational read, valid same cycle as mem_addr).
- mem_wr_en  out  1  data-memory write strobe (memory writes on rising clk).
- mem_wr_data  out  8  data-memory write data.
- min_dist  out  16  final minimum distance.
- max_dist  out  16  final maximum distance.
- min_k, min_j  out  5 each  operand indices of the min pair (k>j).
- max_k, max_j  out  5 each  operand indices of the max pair (k>j).

Behaviour:
- Reset (reset=0, async): state=IDLE. done=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0. min_dist=16'hFFFF, max_dist=0, all indices 0. Internal cache is not cleared.
- Operand format: value i = {mem[SRC_BASE+2i], mem[SRC_BASE+2i+1]} (big-endian), two's complement.
- IDLE:
  - start=1 at an edge -> LOAD.
  - min_dist/max_dist/indices are re-initialised to reset values on entry to LOAD.
- LOAD (64 cycles):
  - byte counter b=0..63; mem_addr=SRC_BASE+b.
  - mem_rd_data is captured into cache[b>>1], high byte when b even.
  - After b=63 -> PAIR with j=0, k=1.
- PAIR (496 cycles, one pair per cycle):
  - diff = 17-bit signed cache[j]-cache[k]; dist = |diff| in 16 bits (max 65535).
  - Pair (0,1) loads both min and max unconditionally.
  - Every later pair updates min only if dist<min_dist and max only if dist>max_dist (strict), so ties keep the earliest pair in j-major, k-ascending order.
  - Iteration: k++. When k=31: j++, k=j+2. After (30,31) -> WRITE.
  - mem_wr_en=0 throughout.
- WRITE (4 cycles):
  - mem_wr_en=1; addresses RES_BASE..+3.
  - Data in order: min_dist[15:8], min_dist[7:0], max_dist[15:8], max_dist[7:0].
  - Then -> DONE.
- DONE:
  - done=1 and results held.
  - start=1 -> LOAD next cycle; done falls on that same edge.
- Latency: the edge that samples start in IDLE is followed by exactly 564 busy cycles (64+496+4); done=1 on the 565th edge.
- start during LOAD/PAIR/WRITE is ignored; no restart and no abort.
- Reset mid-operation: immediate return to IDLE. Any WRITE in progress is cut off, so partial result bytes may remain in memory. No further writes occur.
- Outside LOAD/WRITE, mem_addr=0 and mem_wr_en=0.

Test Plan:
- All 32 values = 100 -> min_dist=0, max_dist=0, min (k,j)=(1,0), max (k,j)=(1,0); mem[66..69]=00,00,00,00; done at edge 565.
- Values 0 = -32768, 31 = 32767, rest 0 -> max_dist=65535, max (31,0); min_dist=0, min (2,1); mem[68..69]=FF,FF.
- Values i*3 (i=0..31) -> min_dist=3 at (1,0); max_dist=93 at (31,0); ties resolve to the earliest pair.
- Random set, same as the software golden model -> min/max/indices and mem[66..69] match; no writes outside 66..69.
- start pulsed mid-PAIR -> no effect, done still at edge 565. Reset at cycle 300 -> done=0, outputs at reset values, no writes. New start -> full correct run.
- Two back-to-back runs with start held high in DONE and the operands changed -> second run restarts, done low for 564 cycles, second results are correct.
